// File: rtl/button_conditioner_if.sv
// Button inputs and conditioned control outputs between the panel and the
// traffic-light controller.
interface button_conditioner_if;
  logic       btn_start, btn_pause, btn_stopa, btn_stopb;
  logic       start, pause, stopa, stopb;
  logic [3:0] btn_db;

  modport master (output btn_start, btn_pause, btn_stopa, btn_stopb,
                  input  start, pause, stopa, stopb, btn_db);
  modport slave  (input  btn_start, btn_pause, btn_stopa, btn_stopb,
                  output start, pause, stopa, stopb, btn_db);
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces four push buttons, then turns press events into
// start pulse, pause toggle and latched emergency-stop levels.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);
  localparam int NB = 4;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: {stopb, stopa, pause, start}
  logic [NB-1:0]         w_raw, r_sync1, r_sync2, r_db, r_db_q, w_press;
  logic [NB-1:0][CW-1:0] r_cnt;
  logic                  r_start, r_pause, r_stopa, r_stopb;

  assign w_raw = {bus.btn_stopb, bus.btn_stopa, bus.btn_pause, bus.btn_start};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db_q  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_db
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_cnt[g] <= '0;
        r_db[g]  <= 1'b0;
      end else if (r_sync2[g] == r_db[g]) begin
        r_cnt[g] <= '0;
      end else if (r_cnt[g] == CMAX) begin
        r_db[g]  <= r_sync2[g];
        r_cnt[g] <= '0;
      end else begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
  end

  // Rising edge of the debounced level; releases produce nothing.
  assign w_press = r_db & ~r_db_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start <= 1'b0;
      r_pause <= 1'b0;
      r_stopa <= 1'b0;
      r_stopb <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_press[2] || w_press[3]) begin
        if (w_press[2]) r_stopa <= 1'b1;
        if (w_press[3]) r_stopb <= 1'b1;
        r_pause <= 1'b0;
      end else if (w_press[0]) begin
        // A start while a stop button is still held does nothing at all.
        if (!(r_db[2] || r_db[3])) begin
          if (r_stopa || r_stopb) begin
            r_stopa <= 1'b0;
            r_stopb <= 1'b0;
          end else begin
            r_start <= 1'b1;
          end
        end
      end else if (w_press[1] && !r_stopa && !r_stopb) begin
        r_pause <= ~r_pause;
      end
    end
  end

  assign bus.start  = r_start;
  assign bus.pause  = r_pause;
  assign bus.stopa  = r_stopa;
  assign bus.stopb  = r_stopb;
  assign bus.btn_db = r_db;
endmodule
